// File: rtl/msi001_pkg.sv
// Shared definitions for the MSI001 tuner configuration path:
// word width, the power-up register table and the controller state encoding.
package msi001_pkg;

    localparam int MSI001_WORD_W = 24;

    // Power-up register image; only the first N_INIT entries are sent.
    localparam logic [MSI001_WORD_W-1:0] MSI001_INIT_WORDS [16] = '{
        24'h0F3A10, 24'h0000E1, 24'h1C8052, 24'h3A05C3,
        24'h000004, 24'h000005, 24'h000006, 24'h000007,
        24'h000008, 24'h000009, 24'h00000A, 24'h00000B,
        24'h00000C, 24'h00000D, 24'h00000E, 24'h00000F
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_GAP
    } msi001_state_e;

endpackage

// File: rtl/msi001_spi_shift.sv
// 24-bit MSB-first serialiser with SCLK phase generation; done flags the
// final cycle of the last bit slot.
module msi001_spi_shift
    import msi001_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [MSI001_WORD_W-1:0] word,
    output logic                     sdata,
    output logic                     sclk,
    output logic                     done
);

    localparam logic [4:0] DIV_L    = 5'(CLK_DIV);
    localparam logic [4:0] PH_MAX_L = 5'(2 * CLK_DIV - 1);

    logic [MSI001_WORD_W-1:0] shreg_q;
    logic [4:0]               phase_q;
    logic [4:0]               bit_q;
    logic                     active_q;
    logic                     sdata_q;
    logic                     sclk_q;

    assign done  = active_q && (phase_q == PH_MAX_L) && (bit_q == 5'd0);
    assign sdata = sdata_q;
    assign sclk  = sclk_q;

    // Data only moves at slot wrap, so it is stable across the whole high phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q  <= '0;
            phase_q  <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
            sdata_q  <= 1'b0;
            sclk_q   <= 1'b0;
        end else if (load) begin
            shreg_q  <= word;
            sdata_q  <= word[MSI001_WORD_W-1];
            sclk_q   <= 1'b0;
            phase_q  <= '0;
            bit_q    <= 5'(MSI001_WORD_W - 1);
            active_q <= 1'b1;
        end else if (active_q) begin
            if (phase_q == PH_MAX_L) begin
                phase_q <= '0;
                sclk_q  <= 1'b0;
                if (bit_q == 5'd0) begin
                    active_q <= 1'b0;
                    sdata_q  <= 1'b0;
                end else begin
                    bit_q   <= bit_q - 5'd1;
                    shreg_q <= {shreg_q[MSI001_WORD_W-2:0], 1'b0};
                    sdata_q <= shreg_q[MSI001_WORD_W-2];
                end
            end else begin
                phase_q <= phase_q + 5'd1;
                sclk_q  <= ((phase_q + 5'd1) >= DIV_L);
            end
        end
    end

endmodule

// File: rtl/msi001_cfg_ctrl.sv
// MSI001 3-wire configuration controller: replays the init table after reset
// or reinit, then serialises host words, with init always taking priority.
module msi001_cfg_ctrl
    import msi001_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 8,
    parameter int N_INIT     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reinit,
    input  logic                     host_req,
    input  logic [MSI001_WORD_W-1:0] host_word,
    output logic                     host_ack,
    output logic                     busy,
    output logic                     init_done,
    output logic                     spi_data,
    output logic                     spi_clk,
    output logic                     spi_en
);

    msi001_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] init_ptr_q, init_ptr_d;
    logic       init_pend_q, init_pend_d;
    logic       init_done_q, init_done_d;
    logic       src_host_q, src_host_d;
    logic       run_q;
    logic       host_ack_q, host_ack_d;
    logic       busy_q, busy_d;
    logic       spi_en_q, spi_en_d;
    logic       shift_done;
    logic [MSI001_WORD_W-1:0] load_word;

    assign load_word = src_host_q ? host_word : MSI001_INIT_WORDS[init_ptr_q[3:0]];

    msi001_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (state_q == ST_LOAD),
        .word  (load_word),
        .sdata (spi_data),
        .sclk  (spi_clk),
        .done  (shift_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            init_ptr_q  <= '0;
            init_pend_q <= 1'b1;
            init_done_q <= 1'b0;
            src_host_q  <= 1'b0;
            run_q       <= 1'b0;
            host_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            spi_en_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_ptr_q  <= init_ptr_d;
            init_pend_q <= init_pend_d;
            init_done_q <= init_done_d;
            src_host_q  <= src_host_d;
            run_q       <= 1'b1;
            host_ack_q  <= host_ack_d;
            busy_q      <= busy_d;
            spi_en_q    <= spi_en_d;
        end
    end

    // run_q holds off the first selection by one cycle after reset release.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_ptr_d  = init_ptr_q;
        init_pend_d = init_pend_q;
        init_done_d = init_done_q;
        src_host_d  = src_host_q;
        case (state_q)
            ST_IDLE: begin
                if (run_q) begin
                    if (init_pend_q || reinit) begin
                        state_d    = ST_LOAD;
                        src_host_d = 1'b0;
                    end else if (host_req) begin
                        state_d    = ST_LOAD;
                        src_host_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                if (!src_host_q) begin
                    init_ptr_d = init_ptr_q + 5'd1;
                    if ((init_ptr_q + 5'd1) == 5'(N_INIT)) begin
                        init_pend_d = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_LATCH;
                    cnt_d   = 8'(CLK_DIV - 1);
                end
            end
            ST_LATCH: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_GAP;
                    cnt_d   = 8'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    if (!init_pend_q && (init_ptr_q == 5'(N_INIT))) begin
                        init_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (reinit) begin
            init_pend_d = 1'b1;
            init_ptr_d  = '0;
            init_done_d = 1'b0;
        end
    end

    always_comb begin
        host_ack_d = (state_q == ST_IDLE) && (state_d == ST_LOAD) && src_host_d;
        busy_d     = (state_d != ST_IDLE) || init_pend_d;
        spi_en_d   = !((state_d == ST_SHIFT) || (state_d == ST_LATCH));
    end

    assign host_ack  = host_ack_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign spi_en    = spi_en_q;

endmodule

// File: tb/tb_msi001_cfg_ctrl.sv
// Bench for msi001_cfg_ctrl: directed stimulus pushes expected frames into a
// queue; a pin-level monitor decodes frames and checks them against it.
module tb_msi001_cfg_ctrl;

    localparam int CLK_DIV = 2;
    localparam int GAP     = 8;
    localparam int NI      = 4;
    localparam int EN_LOW  = 49 * CLK_DIV;
    localparam int SP_MIN  = 1 + 49 * CLK_DIV + GAP;
    localparam int SP_MAX  = SP_MIN + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reinit = 1'b0;
    logic        host_req = 1'b0;
    logic [23:0] host_word = '0;
    logic        host_ack, busy, init_done, spi_data, spi_clk, spi_en;

    msi001_cfg_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .N_INIT(NI)) dut (
        .clk       (clk),
        .reset     (reset),
        .reinit    (reinit),
        .host_req  (host_req),
        .host_word (host_word),
        .host_ack  (host_ack),
        .busy      (busy),
        .init_done (init_done),
        .spi_data  (spi_data),
        .spi_clk   (spi_clk),
        .spi_en    (spi_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] w;
        bit          is_init;
        int          idx;
    } exp_t;

    exp_t        q[$];
    logic [23:0] init_tab [4];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // monitor state
    bit          in_frame = 0;
    logic [23:0] word_acc;
    int          rises, en_len, hold_err, fstart;
    logic        sclk_prev = 1'b0, data_prev = 1'b0;
    int          prev_init_idx = -1, prev_init_start = 0;
    int          done_chk_cyc = 0;
    bit          chk_first = 0;
    int          rel_cyc = 0;
    int          last_ack = -100000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            e.w = init_tab[i]; e.is_init = 1; e.idx = i;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            in_frame  = 0;
            sclk_prev = 1'b0;
            data_prev = 1'b0;
        end else begin
            if (host_ack) begin
                exp_t e;
                chk("ack_after_init", init_done, 1'b1);
                checks++;
                if (cyc - last_ack < SP_MIN) begin
                    errors++;
                    $display("FAIL ack_spacing: got %0d cycles required >= %0d", cyc - last_ack, SP_MIN);
                end
                last_ack = cyc;
                e.w = host_word; e.is_init = 0; e.idx = 0;
                q.push_back(e);
                $display("ack  cyc=%0d word=%06h", cyc, host_word);
            end
            if (done_chk_cyc != 0 && cyc == done_chk_cyc - 1) chk("init_done_before", init_done, 1'b0);
            if (done_chk_cyc != 0 && cyc == done_chk_cyc) begin
                chk("init_done_rise", init_done, 1'b1);
                done_chk_cyc = 0;
            end
            if (!spi_en) begin
                if (!in_frame) begin
                    in_frame = 1; rises = 0; en_len = 0; hold_err = 0; fstart = cyc; word_acc = '0;
                    chk("frame_first_sclk", spi_clk, 1'b0);
                    if (chk_first) begin
                        chk("first_frame_latency", fstart - rel_cyc, 3);
                        chk_first = 0;
                    end
                end
                en_len++;
                if (spi_clk && !sclk_prev) begin
                    word_acc = {word_acc[22:0], spi_data};
                    rises++;
                end
                if (spi_clk && sclk_prev && spi_data != data_prev) hold_err++;
            end else if (in_frame) begin
                in_frame = 0;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL frame_unexpected: got word %06h required none", word_acc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("frame cyc=%0d word=%06h exp=%06h en_low=%0d", fstart, word_acc, e.w, en_len);
                    chk("frame_word", word_acc, e.w);
                    chk("en_low_len", en_len, EN_LOW);
                    chk("sclk_rises", rises, 24);
                    chk("data_hold", hold_err, 0);
                    if (e.is_init) begin
                        if (e.idx > 0 && prev_init_idx == e.idx - 1) begin
                            checks++;
                            if (fstart - prev_init_start < SP_MIN || fstart - prev_init_start > SP_MAX) begin
                                errors++;
                                $display("FAIL init_spacing: got %0d required %0d..%0d",
                                         fstart - prev_init_start, SP_MIN, SP_MAX);
                            end
                        end
                        prev_init_idx   = e.idx;
                        prev_init_start = fstart;
                        if (e.idx == NI - 1) done_chk_cyc = cyc + GAP;
                    end else begin
                        prev_init_idx = -1;
                    end
                end
            end
            sclk_prev = spi_clk;
            data_prev = spi_data;
        end
    end

    task automatic host_send(input logic [23:0] w, input bit keep);
        bit got;
        got = 0;
        host_word = w;
        host_req  = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk); #1;
            if (host_ack) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL host_ack_timeout: got none required ack for %06h", w);
        end
        @(posedge clk); #1;
        if (!keep) host_req = 1'b0;
    endtask

    task automatic wait_sig(input string name, input bit want_busy_low);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            if (want_busy_low ? !busy : init_done) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout: condition not reached", name);
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        rel_cyc = cyc;
        chk_first = 1;
        push_init();
        @(posedge clk); #1;
        chk("busy_after_release", busy, 1'b1);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        init_tab = '{24'h0F3A10, 24'h0000E1, 24'h1C8052, 24'h3A05C3};
        repeat (4) @(posedge clk);
        #1;
        chk("rst_spi_en", spi_en, 1'b1);
        chk("rst_spi_clk", spi_clk, 1'b0);
        chk("rst_spi_data", spi_data, 1'b0);
        chk("rst_host_ack", host_ack, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_init_done", init_done, 1'b0);

        // host request raised during init must wait for init_done
        release_reset();
        host_send(24'hA5C3F0, 0);
        wait_sig("idle1", 1);

        // request held across two words
        host_send(24'h123456, 1);
        host_send(24'h9ABCDE, 0);
        wait_sig("idle2", 1);

        // reinit during a host frame
        host_send(24'h0F0F0F, 0);
        repeat (30) @(posedge clk);
        #1 reinit = 1'b1;
        push_init();
        @(posedge clk); #1;
        reinit = 1'b0;
        chk("reinit_clears_done", init_done, 1'b0);
        wait_sig("done2", 0);
        wait_sig("idle3", 1);

        // reinit and host_req in the same idle cycle
        host_word = 24'h3C3C3C;
        host_req  = 1'b1;
        reinit    = 1'b1;
        push_init();
        @(posedge clk); #1;
        reinit = 1'b0;
        host_send(24'h3C3C3C, 0);
        wait_sig("idle4", 1);

        // reset during bit 12 of an init frame
        reinit = 1'b1;
        push_init();
        @(posedge clk); #1;
        reinit = 1'b0;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            if (in_frame && rises == 11) ok = 1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL bit12_timeout: frame never reached bit 12");
        end
        reset = 1'b1;
        q.delete();
        done_chk_cyc  = 0;
        prev_init_idx = -1;
        @(posedge clk); #1;
        chk("midrst_spi_en", spi_en, 1'b1);
        chk("midrst_spi_clk", spi_clk, 1'b0);
        chk("midrst_spi_data", spi_data, 1'b0);
        release_reset();
        wait_sig("done3", 0);
        wait_sig("idle5", 1);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
